biquad_coeff_loader: RTL and testbench

//  Drives the serial coefficient bus (coeff_dat/coeff_wr/coeff_update) of the incremental biquad DSP chain.

---
 rtl/biquad_coeff_loader.sv | 117 +++++++++++
 tb/tb_biquad_coeff_loader.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/biquad_coeff_loader.sv
// Coefficient loader for the incremental biquad chain: host-writable staging file
// streamed farthest-DSP-first onto the serial coeff bus, followed by one B2 update strobe.
module biquad_coeff_loader #(
  parameter int unsigned NSAMP      = 8,
  parameter int unsigned NCOEFF     = 2 * (NSAMP - 2),
  parameter int unsigned ADDRBITS   = $clog2(NCOEFF),
  parameter int unsigned UPDATE_GAP = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDRBITS-1:0] cfg_addr_i,
  input  logic [17:0]         cfg_dat_i,
  input  logic                cfg_wr_i,
  output logic [17:0]         cfg_dat_o,
  input  logic                go_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o,
  output logic [17:0]         coeff_dat_o,
  output logic                coeff_wr_o,
  output logic                coeff_update_o
);

  localparam int unsigned DW = 18;
  localparam int unsigned GW = 3;
  localparam logic [ADDRBITS:0] NC_L = (ADDRBITS + 1)'(NCOEFF);

  typedef enum logic [2:0] {IDLE, SHIFT, GAP, UPDATE, DONE} state_t;

  state_t              state;
  logic [DW-1:0]       staging [NCOEFF];
  logic [ADDRBITS-1:0] idx;
  logic [GW-1:0]       gap_cnt;

  logic addr_ok_c;
  logic wr_ok_c;
  logic go_ok_c;
  logic err_evt_c;

  // Staging writes are only legal while idle, so the file is stable for a whole load.
  assign addr_ok_c = {1'b0, cfg_addr_i} < NC_L;
  assign wr_ok_c   = cfg_wr_i && (state == IDLE) && addr_ok_c;
  assign go_ok_c   = go_i && (state == IDLE);
  assign err_evt_c = (cfg_wr_i && !wr_ok_c) || (go_i && (state != IDLE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NCOEFF); i++) staging[i] <= '0;
    end else if (wr_ok_c) begin
      staging[cfg_addr_i] <= cfg_dat_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cfg_dat_o <= '0;
    else     cfg_dat_o <= addr_ok_c ? staging[cfg_addr_i] : '0;
  end

  // Load sequencer; data is registered from the index of the previous strobe clock,
  // so coeff_dat_o trails coeff_wr_o by exactly one clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      idx            <= '0;
      gap_cnt        <= '0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      err_o          <= 1'b0;
      coeff_dat_o    <= '0;
      coeff_wr_o     <= 1'b0;
      coeff_update_o <= 1'b0;
    end else begin
      err_o          <= err_evt_c || (err_o && !go_ok_c);
      coeff_dat_o    <= coeff_wr_o ? staging[idx] : '0;
      coeff_wr_o     <= 1'b0;
      coeff_update_o <= 1'b0;
      done_o         <= 1'b0;
      busy_o         <= 1'b0;
      case (state)
        IDLE: begin
          if (go_ok_c) begin
            state      <= SHIFT;
            idx        <= ADDRBITS'(NCOEFF - 1);
            coeff_wr_o <= 1'b1;
            busy_o     <= 1'b1;
          end
        end
        SHIFT: begin
          busy_o <= 1'b1;
          if (idx == '0) begin
            state   <= GAP;
            gap_cnt <= GW'(UPDATE_GAP - 2);
          end else begin
            idx        <= idx - 1'b1;
            coeff_wr_o <= 1'b1;
          end
        end
        GAP: begin
          busy_o <= 1'b1;
          if (gap_cnt == '0) begin
            state          <= UPDATE;
            coeff_update_o <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        UPDATE: begin
          state  <= DONE;
          done_o <= 1'b1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_biquad_coeff_loader.sv
// Directed bench for biquad_coeff_loader: two instances (UPDATE_GAP 2 and 5)
// sharing clock, reset and config address/data.
module tb_biquad_coeff_loader;

  localparam int unsigned NC = 12;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  cfg_addr = '0;
  logic [17:0] cfg_dat = '0;
  logic        cfg_wr_a = 1'b0, cfg_wr_b = 1'b0;
  logic        go_a = 1'b0, go_b = 1'b0;

  logic [17:0] a_rd, a_dat, b_rd, b_dat;
  logic        a_busy, a_done, a_err, a_wr, a_upd;
  logic        b_busy, b_done, b_err, b_wr, b_upd;

  int n_checks = 0;
  int n_err    = 0;
  int upd_cnt_a = 0;
  logic [17:0] exp_stage [NC];

  always #5 clk = ~clk;

  biquad_coeff_loader #(.NSAMP(8), .UPDATE_GAP(2)) dut_a (
    .clk(clk), .rst(rst), .cfg_addr_i(cfg_addr), .cfg_dat_i(cfg_dat), .cfg_wr_i(cfg_wr_a),
    .cfg_dat_o(a_rd), .go_i(go_a), .busy_o(a_busy), .done_o(a_done), .err_o(a_err),
    .coeff_dat_o(a_dat), .coeff_wr_o(a_wr), .coeff_update_o(a_upd));

  biquad_coeff_loader #(.NSAMP(8), .UPDATE_GAP(5)) dut_b (
    .clk(clk), .rst(rst), .cfg_addr_i(cfg_addr), .cfg_dat_i(cfg_dat), .cfg_wr_i(cfg_wr_b),
    .cfg_dat_o(b_rd), .go_i(go_b), .busy_o(b_busy), .done_o(b_done), .err_o(b_err),
    .coeff_dat_o(b_dat), .coeff_wr_o(b_wr), .coeff_update_o(b_upd));

  // Biquad receive model: strobes registered once before the B1 shift and B2 load.
  logic [17:0] b1 [NC];
  logic [17:0] b2 [NC];
  logic        wr_q = 1'b0, upd_q = 1'b0;
  always @(posedge clk) begin
    wr_q  <= a_wr;
    upd_q <= a_upd;
    if (wr_q) begin
      b1[0] <= a_dat;
      for (int j = 1; j < int'(NC); j++) b1[j] <= b1[j-1];
    end
    if (upd_q) b2 <= b1;
    if (a_upd) upd_cnt_a <= upd_cnt_a + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] obs_bus(input int which);
    if (which == 0) return {10'd0, a_wr, a_upd, a_done, a_busy, a_dat};
    return {10'd0, b_wr, b_upd, b_done, b_busy, b_dat};
  endfunction

  // Expected bus state in clock c of a load that was accepted at clock 0.
  function automatic logic [31:0] exp_bus(input int c, input int gap);
    logic        wr, upd, dn, bsy;
    logic [17:0] d;
    wr  = (c >= 1) && (c <= int'(NC));
    upd = (c == int'(NC) + gap);
    dn  = (c == int'(NC) + gap + 1);
    bsy = (c >= 1) && (c <= int'(NC) + gap);
    d   = ((c >= 2) && (c <= int'(NC) + 1)) ? exp_stage[int'(NC) + 1 - c] : 18'd0;
    return {10'd0, wr, upd, dn, bsy, d};
  endfunction

  // Caller raises go before calling; checks clocks 1 .. DONE, optionally injecting
  // a write + second go into dut_a at clock inj.
  task automatic run_load(input int which, input int gap, input int inj);
    for (int c = 1; c <= int'(NC) + gap + 1; c++) begin
      @(negedge clk);
      if (c == 1) begin
        go_a = 1'b0; go_b = 1'b0; cfg_wr_a = 1'b0; cfg_wr_b = 1'b0;
      end
      if (inj != 0 && c == inj) begin
        cfg_addr = 4'd0; cfg_dat = 18'h555; cfg_wr_a = 1'b1; go_a = 1'b1;
      end
      if (inj != 0 && c == inj + 1) begin
        cfg_wr_a = 1'b0; go_a = 1'b0;
      end
      check($sformatf("load%0d_c%0d", which, c), obs_bus(which), exp_bus(c, gap));
    end
  endtask

  task automatic wr_stage(input logic [3:0] addr, input logic [17:0] data);
    cfg_addr = addr; cfg_dat = data; cfg_wr_a = 1'b1; cfg_wr_b = 1'b1;
    @(negedge clk);
    cfg_wr_a = 1'b0; cfg_wr_b = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [3:0] addr, input logic [17:0] exp);
    cfg_addr = addr;
    @(negedge clk);
    check(tag, 32'(a_rd), 32'(exp));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_bus", obs_bus(0), 32'd0);
    check("rst_err", 32'(a_err), 32'd0);
    check("rst_rd", 32'(a_rd), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // T2: nominal load
    for (int i = 0; i < int'(NC); i++) begin
      exp_stage[i] = 18'h100 + 18'(i);
      wr_stage(4'(i), exp_stage[i]);
    end
    rd_check("rd3", 4'd3, 18'h103);
    go_a = 1'b1;
    run_load(0, 2, 0);
    @(negedge clk);
    check("t2_idle", obs_bus(0), 32'd0);
    for (int j = 0; j < int'(NC); j++)
      check($sformatf("b2_dsp%0d", j), 32'(b2[j]), 32'h100 + 32'(j));
    check("t2_err", 32'(a_err), 32'd0);
    check("t2_upd_cnt", 32'(upd_cnt_a), 32'd1);

    // T1: reset mid-shift
    go_a = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      go_a = 1'b0;
    end
    rst = 1'b1;
    #1;
    check("t1_rst_bus", obs_bus(0), 32'd0);
    repeat (3) @(negedge clk);
    check("t1_rst_hold", obs_bus(0), 32'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("t1_no_upd", 32'(upd_cnt_a), 32'd1);
    check("t1_idle", obs_bus(0), 32'd0);
    rd_check("t1_stage_clr", 4'd11, 18'd0);

    // T3: out-of-range write
    for (int i = 0; i < int'(NC); i++) begin
      exp_stage[i] = 18'h200 + 18'(i);
      wr_stage(4'(i), exp_stage[i]);
    end
    wr_stage(4'd12, 18'h2AAAA);
    check("t3_err", 32'(a_err), 32'd1);
    rd_check("t3_rd12", 4'd12, 18'd0);
    rd_check("t3_rd11", 4'd11, 18'h20B);
    go_a = 1'b1;
    run_load(0, 2, 0);
    check("t3_err_clr", 32'(a_err), 32'd0);

    // T4: write + go while busy
    @(negedge clk);
    go_a = 1'b1;
    run_load(0, 2, 5);
    check("t4_err", 32'(a_err), 32'd1);
    check("t4_upd_cnt", 32'(upd_cnt_a), 32'd3);
    rd_check("t4_rd0", 4'd0, 18'h200);

    // T5: write coinciding with go
    cfg_addr = 4'd11; cfg_dat = 18'h3FFFF; cfg_wr_a = 1'b1; cfg_wr_b = 1'b1; go_a = 1'b1;
    exp_stage[11] = 18'h3FFFF;
    run_load(0, 2, 0);
    check("t5_err_clr", 32'(a_err), 32'd0);

    // T6: UPDATE_GAP=5 and back-to-back go
    @(negedge clk);
    go_b = 1'b1;
    run_load(1, 5, 0);
    check("t6_err_pre", 32'(b_err), 32'd0);
    go_b = 1'b1;
    @(negedge clk);
    check("t6_rej_err", 32'(b_err), 32'd1);
    check("t6_rej_busy", 32'(b_busy), 32'd0);
    @(negedge clk);
    go_b = 1'b0;
    check("t6_acc_err", 32'(b_err), 32'd0);
    check("t6_acc_bus", obs_bus(1), exp_bus(1, 5));
    repeat (25) @(negedge clk);
    check("t6_final_idle", obs_bus(1), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
